// File: rtl/z80_bus_arbiter.sv
// Round-robin arbiter that lends the Z80 bus to two DMA masters via BUSRQ/BUSAK; all outputs registered.
// Latency: busrq_n falls 1 cycle after req, gnt rises 1 cycle after busak_n low; requesters hold req as backpressure.
module z80_bus_arbiter #(
    parameter int unsigned MAX_HOLD    = 256,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic       ext_bus_en,
    output logic       preempt,
    output logic       ack_err,
    input  logic       err_clr,
    output logic       last_owner
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [15:0] ACK_LIM  = 16'(ACK_TIMEOUT);
    localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD - 1);

    logic [1:0]  state;
    logic        owner;
    logic        granted;
    logic [15:0] ack_cnt;
    logic [15:0] hold_cnt;
    logic [15:0] ack_inc;
    logic [15:0] hold_inc;

    // Saturating increments so a stuck bus never wraps the counters.
    always_comb begin
        ack_inc  = (ack_cnt == 16'hFFFF) ? ack_cnt : ack_cnt + 16'd1;
        hold_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            granted    <= 1'b0;
            ack_cnt    <= 16'd0;
            hold_cnt   <= 16'd0;
            gnt        <= 2'b00;
            busrq_n    <= 1'b1;
            ext_bus_en <= 1'b0;
            preempt    <= 1'b0;
            ack_err    <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            preempt <= 1'b0;
            case (state)
                S_IDLE: begin
                    gnt        <= 2'b00;
                    ext_bus_en <= 1'b0;
                    busrq_n    <= 1'b1;
                    if (req != 2'b00) begin
                        owner   <= (req == 2'b11) ? ~last_owner : req[1];
                        busrq_n <= 1'b0;
                        ack_cnt <= 16'd0;
                        granted <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    ack_cnt <= ack_inc;
                    if (!req[owner]) begin
                        busrq_n <= 1'b1;
                        state   <= S_RELEASE;
                    end else if (!busak_n) begin
                        gnt        <= owner ? 2'b10 : 2'b01;
                        ext_bus_en <= 1'b1;
                        hold_cnt   <= 16'd0;
                        granted    <= 1'b1;
                        state      <= S_GRANT;
                    end else if (ack_inc >= ACK_LIM) begin
                        ack_err <= 1'b1;
                        busrq_n <= 1'b1;
                        state   <= S_RELEASE;
                    end
                end
                S_GRANT: begin
                    // Requester done, CPU reclaimed the bus, or hold budget spent.
                    if (!req[owner] || busak_n || (hold_cnt >= HOLD_LIM)) begin
                        gnt        <= 2'b00;
                        ext_bus_en <= 1'b0;
                        busrq_n    <= 1'b1;
                        preempt    <= req[owner] && !busak_n;
                        state      <= S_RELEASE;
                    end else begin
                        hold_cnt <= hold_inc;
                    end
                end
                default: begin
                    gnt        <= 2'b00;
                    ext_bus_en <= 1'b0;
                    busrq_n    <= 1'b1;
                    if (busak_n) begin
                        if (granted) last_owner <= owner;
                        state <= S_IDLE;
                    end
                end
            endcase
            if (err_clr) ack_err <= 1'b0;
        end
    end

endmodule
